// File: rtl/tia_playfield_sequencer.sv
// tia_playfield_sequencer: TIA-style playfield line sequencer producing one pixel per color clock.
module tia_playfield_sequencer #(
  parameter int LINE_CLKS   = 228,
  parameter int HBLANK_CLKS = 68
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line_start,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] hcount,
  output logic       pf_out,
  output logic [4:0] pf_bit,
  output logic       right_half,
  output logic [1:0] score_sel,
  output logic       pf_priority
);
  typedef enum logic [1:0] {HBLANK, LEFT, RIGHT} state_t;
  localparam logic [7:0] LAST = 8'(LINE_CLKS - 1);
  localparam logic [7:0] HB   = 8'(HBLANK_CLKS);
  localparam logic [7:0] RB   = 8'(HBLANK_CLKS + 80);
  state_t      state, state_nx;
  logic [7:0]  pf0, pf1, pf2, h_nx, pos;
  logic [2:0]  ctrl;
  logic [5:0]  g;
  logic [4:0]  b;
  logic [19:0] pf_vec;
  logic        reflect, refl_nx, grp, pix;
  always_comb h_nx = (line_start || hcount == LAST) ? 8'd0 : hcount + 8'd1;
  always_comb begin
    state_nx = state;
    case (state)
      HBLANK:  if (h_nx == HB) state_nx = LEFT;
      LEFT:    if (h_nx == RB) state_nx = RIGHT;
      RIGHT:   if (h_nx == 8'd0) state_nx = HBLANK;
      default: state_nx = HBLANK;
    endcase
    if (line_start) state_nx = HBLANK;
  end
  // Everything is computed for the position being entered, so registered outputs line up with hcount.
  always_comb begin
    pos     = h_nx - HB;
    g       = pos[7:2];
    grp     = state_nx != HBLANK && pos[1:0] == 2'd0;
    refl_nx = (state == LEFT && state_nx == RIGHT) ? ctrl[0] : reflect;
    b       = state_nx == RIGHT ? (refl_nx ? 5'(6'd39 - g) : 5'(g - 6'd20)) : g[4:0];
    pf_vec  = {pf2, 8'd0, pf0[7:4]};
    for (int i = 0; i < 8; i++) pf_vec[4+i] = pf1[7-i];
    pix     = pf_vec[b];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HBLANK;
      hcount      <= 8'd0;
      pf0         <= 8'd0;
      pf1         <= 8'd0;
      pf2         <= 8'd0;
      ctrl        <= 3'd0;
      reflect     <= 1'b0;
      pf_out      <= 1'b0;
      pf_bit      <= 5'd0;
      right_half  <= 1'b0;
      score_sel   <= 2'b00;
      pf_priority <= 1'b0;
    end else begin
      state      <= state_nx;
      hcount     <= h_nx;
      reflect    <= refl_nx;
      right_half <= state_nx == RIGHT;
      pf0        <= (wr_en && wr_addr == 2'd0) ? {wr_data[7:4], 4'd0} : pf0;
      pf1        <= (wr_en && wr_addr == 2'd1) ? wr_data : pf1;
      pf2        <= (wr_en && wr_addr == 2'd2) ? wr_data : pf2;
      ctrl       <= (wr_en && wr_addr == 2'd3) ? wr_data[2:0] : ctrl;
      if (state_nx == HBLANK) begin
        pf_out    <= 1'b0;
        pf_bit    <= 5'd0;
        score_sel <= 2'b00;
      end else if (grp) begin
        pf_out      <= pix;
        pf_bit      <= b;
        score_sel   <= (ctrl[1] && pix) ? (state_nx == RIGHT ? 2'b10 : 2'b01) : 2'b00;
        pf_priority <= ctrl[2];
      end
    end
  end
endmodule

// File: doc/tia_playfield_sequencer.md
TIA_PLAYFIELD_SEQUENCER -- requirements
Module: tia_playfield_sequencer

Interface
REQ-001 SHALL have parameter LINE_CLKS, default 228, color clocks per scan line.
REQ-002 SHALL have parameter HBLANK_CLKS, default 68, blanked color clocks at start of line.
REQ-003 SHALL have port clk  input  1  color clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port line_start  input  1  single-cycle pulse that resynchronises the line to position 0.
REQ-006 SHALL have port wr_en  input  1  register write strobe.
REQ-007 SHALL have port wr_addr  input  2  0=PF0, 1=PF1, 2=PF2, 3=CTRLPF.
REQ-008 SHALL have port wr_data  input  8  write data.
REQ-009 SHALL have port hcount  output  8  current line position, 0..LINE_CLKS-1.
REQ-010 SHALL have port pf_out  output  1  playfield pixel for the current position.
REQ-011 SHALL have port pf_bit  output  5  playfield bit index 0..19 being displayed; 0 during blank.
REQ-012 SHALL have port right_half  output  1  high during the right 80 visible clocks.
REQ-013 SHALL have port score_sel  output  2  colour source: 00=PF, 01=P0, 10=P1.
REQ-014 SHALL have port pf_priority  output  1  CTRLPF D2 as currently applied.

Function
REQ-015 SHALL hold PF0 (D7..D4 only, D3..D0 stored as 0), PF1 and PF2 (8 bits each), and CTRLPF (D2..D0 only).
REQ-016 SHALL capture a write on the clk edge where wr_en is high; an out-of-range bit is ignored.
REQ-017 SHALL advance hcount by 1 per clock and wrap from LINE_CLKS-1 to 0.
REQ-018 SHALL load hcount with 0 on the edge after line_start is high, regardless of current position.
REQ-019 SHALL run state machine HBLANK (hcount < HBLANK_CLKS), LEFT (next 80 clocks), RIGHT (last 80 clocks), with transitions HBLANK->LEFT->RIGHT->HBLANK.
REQ-020 SHALL force line_start to HBLANK from any state.
REQ-021 SHALL divide the visible region into 40 groups of 4 clocks each, 20 groups per half.
REQ-022 SHALL order left-half bits 0..19 as PF0 D4..D7, PF1 D7..D0, PF2 D0..D7.
REQ-023 SHALL display the right half in the same order when CTRLPF D0=0 (repeat), and in bit order 19..0 when D0=1 (reflect).
REQ-024 SHALL sample registers and CTRLPF on the edge entering the first clock of each group, and hold pf_out, pf_bit, score_sel and pf_priority constant for all 4 clocks of the group.
REQ-025 SHALL keep outputs aligned with hcount: during the cycle hcount==h, pf_out is the pixel for h.
REQ-026 SHALL, for a write on the same edge as a group boundary, sample the pre-write value; the new value appears at the next group.
REQ-027 SHALL drive score_sel=01 in LEFT and 10 in RIGHT when CTRLPF D1=1 and pf_out=1; otherwise 00.
REQ-028 SHALL drive pf_out=0, pf_bit=0, right_half=0 and score_sel=00 in HBLANK.
REQ-029 SHALL latch the reflect bit once at the LEFT->RIGHT boundary; a CTRLPF write during RIGHT does not change the bit order until the next line.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously clear hcount, PF0, PF1, PF2, CTRLPF, pf_out, pf_bit, right_half, score_sel and pf_priority to 0, and set the state to HBLANK.
REQ-031 SHALL start counting from hcount=0 on the first clk edge after rst_n rises.
REQ-032 SHALL treat reset asserted mid-line exactly as power-up, with no partial pixel emitted.

Verification
REQ-033 SHALL cover: PF0=F0, PF1=00, PF2=00, repeat; pf_out=1 at hcount 68..83 and 148..163, 0 elsewhere.
REQ-034 SHALL cover: PF2=80, reflect; pf_out=1 at hcount 144..147 and 148..151 (pf_bit 19 twice).
REQ-035 SHALL cover: PF1 written 00->FF on the boundary edge at hcount 84; group 84..87 is 0 and group 88..91 is 1.
REQ-036 SHALL cover: line_start pulsed at hcount 100; hcount=0 next cycle, pf_out=0 through hcount 67.
REQ-037 SHALL cover: CTRLPF=02 with all PF bits set; score_sel=01 at hcount 68..147 and 10 at 148..227.
REQ-038 SHALL cover: rst_n low at hcount 120 with pf_out=1; all outputs 0 immediately, and on release hcount counts 0,1,2.
